// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Arbitrates round-robin or fixed-priority, registers operands, returns a tagged result.
module alu_arbiter #(
  parameter int WIDTH          = 8,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             prio0_s;
  logic             gnt0_s;
  logic             gnt1_s;

  // Grant decode: ready is offered only in IDLE and never while reset is asserted.
  always_comb begin
    prio0_s = FIXED_PRIORITY || (rr_q == 1'b0);
    gnt0_s  = req0_valid && (!req1_valid || prio0_s);
    gnt1_s  = req1_valid && !gnt0_s;
    if (rst_n && (state_q == IDLE)) begin
      req0_ready = gnt0_s;
      req1_ready = gnt1_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Next-state and datapath capture for IDLE -> EXEC -> RESP.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          alu_a_d   = req0_a;
          alu_b_d   = req0_b;
          alu_sel_d = req0_sel;
          rsp_id_d  = 1'b0;
          state_d   = EXEC;
        end else if (req1_ready) begin
          alu_a_d   = req1_a;
          alu_b_d   = req1_b;
          alu_sel_d = req1_sel;
          rsp_id_d  = 1'b1;
          state_d   = EXEC;
        end else begin
          state_d   = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_carry;
        rsp_zero_d  = alu_zero;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Fairness pointer moves on response acceptance, not on grant.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = ~rsp_id_q;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      alu_a_q     <= {WIDTH{1'b0}};
      alu_b_q     <= {WIDTH{1'b0}};
      alu_sel_q   <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share
// the same request stimulus, each driving its own behavioural ALU.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_sel, req1_sel;

  logic       d0_req0_ready, d0_req1_ready, d0_rsp_valid, d0_rsp_id, d0_rsp_carry, d0_rsp_zero, d0_busy;
  logic [7:0] d0_alu_a, d0_alu_b, d0_rsp_data, d0_alu_out;
  logic [1:0] d0_alu_sel;
  logic       d0_alu_carry, d0_alu_zero;

  logic       d1_req0_ready, d1_req1_ready, d1_rsp_valid, d1_rsp_id, d1_rsp_carry, d1_rsp_zero, d1_busy;
  logic [7:0] d1_alu_a, d1_alu_b, d1_rsp_data, d1_alu_out;
  logic [1:0] d1_alu_sel;
  logic       d1_alu_carry, d1_alu_zero;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic [7:0] data;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[8];

  // External ALU: {carry of a+b, zero, result}
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
    logic [8:0]  s;
    logic [15:0] m;
    logic [7:0]  o;
    s = {1'b0, a} + {1'b0, b};
    m = {8'd0, a} * {8'd0, b};
    case (sel)
      2'b00:   o = s[7:0];
      2'b01:   o = m[7:0];
      2'b10:   o = a ^ b;
      2'b11:   o = {a[6:0], 1'b0};
      default: o = 8'd0;
    endcase
    return {s[8], (o == 8'd0), o};
  endfunction

  assign {d0_alu_carry, d0_alu_zero, d0_alu_out} = alu_f(d0_alu_a, d0_alu_b, d0_alu_sel);
  assign {d1_alu_carry, d1_alu_zero, d1_alu_out} = alu_f(d1_alu_a, d1_alu_b, d1_alu_sel);

  alu_arbiter #(.WIDTH(8), .FIXED_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(d0_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(d0_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(d0_alu_a), .alu_b(d0_alu_b), .alu_sel(d0_alu_sel),
    .alu_out(d0_alu_out), .alu_carry(d0_alu_carry), .alu_zero(d0_alu_zero),
    .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d0_rsp_id), .rsp_data(d0_rsp_data),
    .rsp_carry(d0_rsp_carry), .rsp_zero(d0_rsp_zero), .busy(d0_busy)
  );

  alu_arbiter #(.WIDTH(8), .FIXED_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_sel(d1_alu_sel),
    .alu_out(d1_alu_out), .alu_carry(d1_alu_carry), .alu_zero(d1_alu_zero),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id), .rsp_data(d1_rsp_data),
    .rsp_carry(d1_rsp_carry), .rsp_zero(d1_rsp_zero), .busy(d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  // One complete single-requester transaction on the round-robin instance, rsp_ready held high.
  task automatic do_op(input vec_t v);
    drive(v.id, v.a, v.b, v.sel);
    #1;
    chk("grant_ready0", {31'd0, d0_req0_ready}, {31'd0, (v.id == 1'b0)});
    chk("grant_ready1", {31'd0, d0_req1_ready}, {31'd0, (v.id == 1'b1)});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_busy", {31'd0, d0_busy}, 32'd1);
    chk("exec_no_rsp", {31'd0, d0_rsp_valid}, 32'd0);
    chk("alu_a", {24'd0, d0_alu_a}, {24'd0, v.a});
    chk("alu_sel", {30'd0, d0_alu_sel}, {30'd0, v.sel});
    tick();
    chk("rsp_valid", {31'd0, d0_rsp_valid}, 32'd1);
    chk("rsp_id", {31'd0, d0_rsp_id}, {31'd0, v.id});
    chk("rsp_data", {24'd0, d0_rsp_data}, {24'd0, v.data});
    chk("rsp_carry", {31'd0, d0_rsp_carry}, {31'd0, v.c});
    chk("rsp_zero", {31'd0, d0_rsp_zero}, {31'd0, v.z});
    tick();
    chk("back_idle", {31'd0, d0_busy}, 32'd0);
    chk("rsp_cleared", {31'd0, d0_rsp_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    vecs[0] = '{1'b0, 8'd200, 8'd100, 2'b00, 8'd44,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'd16,  8'd16,  2'b01, 8'h00,  1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'hAA,  8'h55,  2'b10, 8'hFF,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h81,  8'h80,  2'b11, 8'h02,  1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF,  8'h01,  2'b00, 8'h00,  1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h80,  8'h00,  2'b11, 8'h00,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h0F,  8'h11,  2'b01, 8'hFF,  1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h7F,  8'h01,  2'b00, 8'h80,  1'b0, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd0; req0_b = 8'd0; req0_sel = 2'b00;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_sel = 2'b00;
    tick();
    tick();
    chk("rst_ready0", {31'd0, d0_req0_ready}, 32'd0);
    chk("rst_busy", {31'd0, d0_busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, d0_rsp_valid}, 32'd0);
    chk("rst_alu_a", {24'd0, d0_alu_a}, 32'd0);
    chk("rst_rsp_data", {24'd0, d0_rsp_data}, 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i]);
    end

    // Both requesters valid continuously: grants every 3 cycles, alternating on dut0, always 0 on dut1.
    drive(1'b0, 8'd1, 8'd2, 2'b00);
    drive(1'b1, 8'd3, 8'd4, 2'b00);
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      chk("rr_ready0", {31'd0, d0_req0_ready}, {31'd0, (cyc % 3 == 0) && ((cyc / 3) % 2 == 0)});
      chk("rr_ready1", {31'd0, d0_req1_ready}, {31'd0, (cyc % 3 == 0) && ((cyc / 3) % 2 == 1)});
      chk("fp_ready0", {31'd0, d1_req0_ready}, {31'd0, (cyc % 3 == 0)});
      chk("fp_ready1", {31'd0, d1_req1_ready}, 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Response back-pressure: everything holds while rsp_ready is low.
    rsp_ready = 1'b0;
    drive(1'b0, 8'd3, 8'd4, 2'b00);
    tick();
    req0_valid = 1'b0;
    drive(1'b1, 8'hF0, 8'h0F, 2'b10);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, d0_rsp_valid}, 32'd1);
      chk("stall_data", {24'd0, d0_rsp_data}, 32'd7);
      chk("stall_id", {31'd0, d0_rsp_id}, 32'd0);
      chk("stall_ready1", {31'd0, d0_req1_ready}, 32'd0);
      chk("stall_busy", {31'd0, d0_busy}, 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("unstall_busy", {31'd0, d0_busy}, 32'd0);
    chk("unstall_rsp", {31'd0, d0_rsp_valid}, 32'd0);
    chk("unstall_ready1", {31'd0, d0_req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("post_stall_id", {31'd0, d0_rsp_id}, 32'd1);
    chk("post_stall_data", {24'd0, d0_rsp_data}, 32'hFF);
    tick();

    // Leave the pointer at requester 1, then reset in EXEC and confirm it returns to 0.
    do_op('{1'b0, 8'd5, 8'd6, 2'b10, 8'd3, 1'b0, 1'b0});
    drive(1'b1, 8'd9, 8'd9, 2'b01);
    tick();
    req1_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, d0_busy}, 32'd1);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    tick();
    chk("mid_rst_rsp", {31'd0, d0_rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, d0_busy}, 32'd0);
    chk("mid_rst_alu", {14'd0, d0_alu_a, d0_alu_b, d0_alu_sel}, 32'd0);
    chk("mid_rst_ready0", {31'd0, d0_req0_ready}, 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dropped_no_rsp", {31'd0, d0_rsp_valid}, 32'd0);
    end
    drive(1'b0, 8'd1, 8'd1, 2'b00);
    drive(1'b1, 8'd1, 8'd1, 2'b00);
    #1;
    chk("rr_after_rst0", {31'd0, d0_req0_ready}, 32'd1);
    chk("rr_after_rst1", {31'd0, d0_req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
